// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 keyboard receiver bus: pin inputs plus decoded key/scan-code outputs.
`timescale 1ns/1ps
interface ps2_keyboard_rx_if;
    logic       ps2c;
    logic       ps2d;
    logic [4:0] keydown;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       code_valid;
    logic       frame_err;

    // Board/top-level side: drives the pins, consumes decoded results
    modport master (
        output ps2c, ps2d,
        input  keydown, code, extended, released, code_valid, frame_err
    );

    // Receiver side
    modport slave (
        input  ps2c, ps2d,
        output keydown, code, extended, released, code_valid, frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard device-to-host receiver: synchronizes and filters the pins,
// frames 11-bit packets, decodes scan-code set 2 make/break/extended codes
// and keeps a 5-bit held-key vector for player movement.
`timescale 1ns/1ps
module ps2_keyboard_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input logic          clk,
    input logic          rst,
    ps2_keyboard_rx_if.slave bus
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FL_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    r_c_sync;
    logic [1:0]    r_d_sync;
    logic          r_c_filt;
    logic          r_c_filt_d;
    logic [FW-1:0] r_fcnt;

    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [TW-1:0] r_tcnt;
    logic          r_par_ok;
    logic [7:0]    r_byte;
    logic          r_ext;
    logic          r_brk;

    logic [4:0]    r_keydown;
    logic [7:0]    r_code;
    logic          r_extended;
    logic          r_released;
    logic          r_code_valid;
    logic          r_frame_err;

    logic          w_fall;
    logic          w_din;
    logic [4:0]    w_mask;

    // Key map: one-hot keydown bit for a scan code, honouring the E0 prefix
    function automatic logic [4:0] key_mask(input logic [7:0] b, input logic e);
        logic [4:0] m;
        m = '0;
        if (!e) begin
            case (b)
                8'h1D:   m = 5'b00001;
                8'h1B:   m = 5'b00010;
                8'h1C:   m = 5'b00100;
                8'h23:   m = 5'b01000;
                8'h29:   m = 5'b10000;
                default: m = '0;
            endcase
        end else begin
            case (b)
                8'h75:   m = 5'b00001;
                8'h72:   m = 5'b00010;
                8'h6B:   m = 5'b00100;
                8'h74:   m = 5'b01000;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    // The filtered clock's falling edge is acted on one cycle after the filter accepts it
    assign w_fall = r_c_filt_d & ~r_c_filt;
    assign w_din  = r_d_sync[1];
    assign w_mask = key_mask(r_byte, r_ext);

    // Two-flop synchronizers; idle-high so reset never fakes an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
        end else begin
            r_c_sync <= {r_c_sync[0], bus.ps2c};
            r_d_sync <= {r_d_sync[0], bus.ps2d};
        end
    end

    // Glitch filter: follow the synchronized clock only after FILTER_LEN agreeing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_filt   <= 1'b1;
            r_c_filt_d <= 1'b1;
            r_fcnt     <= '0;
        end else begin
            r_c_filt_d <= r_c_filt;
            if (r_c_sync[1] != r_c_filt) begin
                if (r_fcnt == FL_LAST) begin
                    r_c_filt <= r_c_sync[1];
                    r_fcnt   <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // Data bits shift in LSB first; contents only matter once a full byte is framed
    always_ff @(posedge clk) begin
        if (w_fall && r_state == S_DATA)
            r_byte <= {w_din, r_byte[7:1]};
    end

    // Frame FSM with inter-edge timeout and scan-code decoder
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= '0;
            r_tcnt       <= '0;
            r_par_ok     <= 1'b0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_keydown    <= '0;
            r_code       <= '0;
            r_extended   <= 1'b0;
            r_released   <= 1'b0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            // Counts cycles since the accepted edge (which was one cycle ago)
            if (w_fall)
                r_tcnt <= TW'(1);
            else if (r_state == S_IDLE)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + 1'b1;

            if (r_state != S_IDLE && !w_fall && r_tcnt == TO_LAST) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_din) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_byte, w_din};
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (r_par_ok && w_din) begin
                            if (r_byte == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_byte == 8'hF0) begin
                                r_brk <= 1'b1;
                            end else begin
                                r_code       <= r_byte;
                                r_extended   <= r_ext;
                                r_released   <= r_brk;
                                r_code_valid <= 1'b1;
                                r_keydown    <= r_brk ? (r_keydown & ~w_mask)
                                                      : (r_keydown | w_mask);
                                r_ext        <= 1'b0;
                                r_brk        <= 1'b0;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_ext       <= 1'b0;
                            r_brk       <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.keydown    = r_keydown;
    assign bus.code       = r_code;
    assign bus.extended   = r_extended;
    assign bus.released   = r_released;
    assign bus.code_valid = r_code_valid;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives the PS/2 keyboard device-to-host serial stream on the board's `ps2c`/`ps2d` pins and reassembles scan-code set 2 frames. It decodes make, break and extended prefixes, and maintains a 5-bit held-key vector that drives the same `keydown` input of the player-movement logic that the debounced push-buttons drive today. It also reports every completed scan code for the seven-segment debug display. It is the input-side counterpart of the board's serial display and video outputs, and it sits in the top level beside the button debouncers.

## Interface
- `FILTER_LEN`, default 8: number of consecutive `clk` cycles the synchronized `ps2c` must hold a level before that level is accepted.
- `TIMEOUT_CYC`, default 20000: maximum number of `clk` cycles between accepted `ps2c` falling edges inside a frame (200 µs at 100 MHz).
- `clk`, input, 1: system clock (100 MHz). Only clock in the block.
- `rst`, input, 1: asynchronous, active-low reset.
- `ps2c`, input, 1: PS/2 clock from the pin (asynchronous).
- `ps2d`, input, 1: PS/2 data from the pin (asynchronous).
- `keydown`, output, 5: held keys, in this order:
  - [0] up: W 0x1D or E0 75
  - [1] down: S 0x1B or E0 72
  - [2] left: A 0x1C or E0 6B
  - [3] right: D 0x23 or E0 74
  - [4] jump: Space 0x29
- `code`, output, 8: last decoded non-prefix scan code. Held until the next decode.
- `extended`, output, 1: `code` was preceded by E0. Held with `code`.
- `released`, output, 1: `code` was preceded by F0. Held with `code`.
- `code_valid`, output, 1: one-cycle pulse when `code`, `extended` and `released` update.
- `frame_err`, output, 1: one-cycle pulse on a start, parity, stop or timeout error.

## Operation
- **Input path:** `ps2c` and `ps2d` each pass through a 2-FF synchronizer. `ps2c` then passes through the glitch filter: the filtered clock changes only after `FILTER_LEN` identical consecutive samples.
- **Sampling:** a falling edge of the filtered clock samples the synchronized `ps2d`.
- **Frame FSM:** IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: a sampled 0 (start bit) moves to DATA. A sampled 1 is ignored; the FSM stays in IDLE and no error is raised.
  - DATA: 8 bits, LSB first, shifted into a byte register. A 3-bit counter moves the FSM to PARITY after bit 7.
  - PARITY: the sampled bit must make the XOR of the 8 data bits and the parity bit equal 1 (odd parity).
  - STOP: the sampled bit must be 1. If parity and stop are both good, the byte is delivered to the decoder. Otherwise `frame_err` pulses. In both cases the FSM returns to IDLE.
- **Timeout:** in any state other than IDLE, a counter runs and clears on each accepted edge. When it reaches `TIMEOUT_CYC`, the FSM goes to IDLE, `frame_err` pulses, and the partial byte is discarded.
- **Decoder,** per delivered byte:
  - E0 sets the `ext` flag.
  - F0 sets the `brk` flag.
  - Any other byte:
    - `code` ← byte, `extended` ← `ext`, `released` ← `brk`.
    - `code_valid` pulses.
    - If the key is mapped: the matching `keydown` bit ← ~`brk`.
    - `ext` and `brk` are cleared.
- **Prefix rules:**
  - Mapping respects `ext`: E0 1D is not "up", and a bare 75 is not "up".
  - `frame_err` clears `ext` and `brk`.
  - `keydown` is never changed by an error.
- **Auto-repeat:** repeated make codes re-pulse `code_valid`. `keydown` stays 1.
- **Reset values:** `keydown` = 0, `code` = 0x00, `extended` = 0, `released` = 0, `code_valid` = 0, `frame_err` = 0, FSM in IDLE, all counters and flags 0. Reset asserted mid-frame discards the frame immediately.

## Timing
- **Pin to accepted edge:** 2 synchronizer cycles + `FILTER_LEN` cycles from a `ps2c` pin transition.
- **End of frame:** `code_valid`, the new `code`/`extended`/`released` and the `keydown` update all appear together, exactly 1 cycle after the stop-bit edge is accepted.
- **Errors:** `frame_err` is asserted 1 cycle after the failing stop-bit edge, or 1 cycle after the timeout count is reached.
- **Pulse width:** `code_valid` and `frame_err` are never high for 2 consecutive cycles. They are never high in the same cycle.
- **Throughput:** back-to-back frames with no idle gap are accepted. The next start bit may arrive on the edge after STOP.

## Test plan
- **Make code:** send frame 0x1C (parity 0, stop 1) → one `code_valid` pulse, `code` = 0x1C, `extended` = 0, `released` = 0, `keydown` = 5'b00100.
- **Break code:** with A held, send F0 then 1C → exactly one `code_valid` pulse (none for the F0 byte), `released` = 1, `keydown` = 0.
- **Extended key:** send E0 74 → `keydown[3]` = 1 and `extended` = 1. Then send E0 F0 74 → `keydown[3]` = 0. Send a bare 0x74 → `keydown` unchanged.
- **Parity error:** send 0x29 with its parity bit inverted → `frame_err` pulse, no `code_valid`, `keydown` unchanged. Then send a valid 0x29 → `keydown[4]` = 1.
- **Timeout and reset:** stop `ps2c` after 5 data bits → `frame_err` exactly `TIMEOUT_CYC` cycles after the last accepted edge, then a valid 0x1D decodes. Assert `rst` = 0 mid-frame → all outputs 0, and the next full frame decodes correctly.
- **Glitch rejection:** a `ps2c` low glitch of `FILTER_LEN`−1 cycles inside a frame → no bit consumed, and the frame still decodes correctly.
